// File: rtl/rs232_rx.sv
// 8N1 serial receiver: double-flop synchronizer, mid-bit sampling FSM and a valid/ack byte handshake.
// Signals framing errors (stop bit low) and overruns (unacknowledged byte overwritten).
module rs232_rx #(
  parameter int BAUD_CNT_MAX = 1302,
  parameter int HALF_CNT     = BAUD_CNT_MAX / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [11:0] BAUD_MAX_C = 12'(BAUD_CNT_MAX);
  localparam logic [11:0] HALF_C     = 12'(HALF_CNT);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t      state_r, state_nxt_s;
  logic        rx_meta_r, rx_sync_r;
  logic [11:0] baud_cnt_r;
  logic [3:0]  bit_cnt_r;
  logic [7:0]  shift_r;
  logic        commit_r;
  logic        baud_clr_s, bit_clr_s, shift_en_s, commit_s, frame_err_s;

  // Next-state and datapath control decode
  always_comb begin
    state_nxt_s = state_r;
    baud_clr_s  = 1'b0;
    bit_clr_s   = 1'b0;
    shift_en_s  = 1'b0;
    commit_s    = 1'b0;
    frame_err_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!rx_sync_r) begin
          state_nxt_s = ST_START;
          baud_clr_s  = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_cnt_r == HALF_C) begin
          if (!rx_sync_r) begin
            state_nxt_s = ST_DATA;
            baud_clr_s  = 1'b1;
            bit_clr_s   = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;  // glitch shorter than half a bit
          end
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_DATA: begin
        if (baud_cnt_r == BAUD_MAX_C) begin
          shift_en_s = 1'b1;
          baud_clr_s = 1'b1;
          if (bit_cnt_r == 4'd7) begin
            state_nxt_s = ST_STOP;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (baud_cnt_r == BAUD_MAX_C) begin
          baud_clr_s = 1'b1;
          if (rx_sync_r) begin
            commit_s    = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            frame_err_s = 1'b1;
            state_nxt_s = ST_BREAK;
          end
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      ST_BREAK: begin
        // a held-low line must not be re-read as start bits
        if (rx_sync_r) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BREAK;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Synchronizer, FSM state, baud/bit counters and shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_r  <= 1'b1;
      rx_sync_r  <= 1'b1;
      state_r    <= ST_IDLE;
      baud_cnt_r <= 12'd0;
      bit_cnt_r  <= 4'd0;
      shift_r    <= 8'h00;
      commit_r   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta_r  <= rx;
      rx_sync_r  <= rx_meta_r;
      state_r    <= state_nxt_s;
      baud_cnt_r <= baud_clr_s ? 12'd0 : baud_cnt_r + 12'd1;
      if (bit_clr_s) begin
        bit_cnt_r <= 4'd0;
      end else if (shift_en_s) begin
        bit_cnt_r <= bit_cnt_r + 4'd1;
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
      shift_r    <= shift_en_s ? {rx_sync_r, shift_r[7:1]} : shift_r;
      commit_r   <= commit_s;
      frame_err  <= frame_err_s;
    end
  end

  // Output byte register and valid/ack handshake with overrun detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (commit_r) begin
        // an ack landing in the commit cycle consumes the old byte, so no overrun
        rx_data  <= shift_r;
        rx_valid <= 1'b1;
        overrun  <= rx_valid & ~rx_ack;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end else begin
        rx_valid <= rx_valid;
      end
    end
  end

endmodule
